id_ex_stage_reg: RTL and testbench

ID/EX pipeline stage register sitting directly downstream of the instruction decode control unit. Captures the decoded control word (ALU opcode, addressing-mode and enable strobes, branch/link flags) plus the decoded operand data and destination register on each clock, and presents them to the execute stage one cycle later. Implements stall (hold), bubble insertion (control cleared, NOP into EX) and branch flush, with an optional hazard statistics counter block.

---
 rtl/id_ex_stage_reg.sv | 129 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register with flush/stall/bubble control.
// Optional hazard statistics counters are built when ID_EX_STATS_EN is defined.
module id_ex_stage_reg #(
  parameter int STATS_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         ID_opcode,
  input  logic               ID_AM,
  input  logic               ID_S_enable,
  input  logic               ID_load_instr,
  input  logic               ID_RF_enable,
  input  logic               ID_Size_enable,
  input  logic               ID_RW_enable,
  input  logic               ID_Enable_signal,
  input  logic               ID_BL_instr,
  input  logic               ID_B_instr,
  input  logic               ID_valid,
  input  logic [31:0]        ID_PA,
  input  logic [31:0]        ID_PB,
  input  logic [31:0]        ID_PD,
  input  logic [11:0]        ID_shift_imm,
  input  logic [3:0]         ID_Rd,
  input  logic [31:0]        ID_next_pc,
  input  logic               stall,
  input  logic               nop_sel,
  input  logic               flush,
  output logic [3:0]         EX_opcode,
  output logic               EX_AM,
  output logic               EX_S_enable,
  output logic               EX_load_instr,
  output logic               EX_RF_enable,
  output logic               EX_Size_enable,
  output logic               EX_RW_enable,
  output logic               EX_Enable_signal,
  output logic               EX_BL_instr,
  output logic               EX_B_instr,
  output logic               EX_valid,
  output logic [31:0]        EX_PA,
  output logic [31:0]        EX_PB,
  output logic [31:0]        EX_PD,
  output logic [11:0]        EX_shift_imm,
  output logic [3:0]         EX_Rd,
  output logic [31:0]        EX_next_pc,
  output logic [STATS_W-1:0] bubble_count,
  output logic [STATS_W-1:0] flush_count
);

  localparam int CTRL_W = 14;
  localparam int DATA_W = 144;

  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_data;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              take_bubble;

  assign id_ctrl = {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
                    ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr,
                    ID_B_instr, ID_valid};
  assign id_data = {ID_PA, ID_PB, ID_PD, ID_shift_imm, ID_Rd, ID_next_pc};

  assign take_bubble = !flush && !stall && nop_sel;

  // Priority flush > stall > nop_sel > load; an invalid slot loads a cleared control word.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (flush) begin
      ctrl_d = '0;
    end else if (stall) begin
      ctrl_d = ctrl_q;
    end else if (nop_sel) begin
      ctrl_d = '0;
      data_d = id_data;
    end else begin
      ctrl_d = ID_valid ? id_ctrl : '0;
      data_d = id_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign {EX_opcode, EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable,
          EX_Size_enable, EX_RW_enable, EX_Enable_signal, EX_BL_instr,
          EX_B_instr, EX_valid} = ctrl_q;
  assign {EX_PA, EX_PB, EX_PD, EX_shift_imm, EX_Rd, EX_next_pc} = data_q;

`ifdef ID_EX_STATS_EN
  logic [STATS_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [STATS_W-1:0] flush_cnt_d, flush_cnt_q;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + {{(STATS_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    bubble_cnt_d = take_bubble ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
    flush_cnt_d  = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_count = bubble_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = take_bubble;
  assign bubble_count  = '0;
  assign flush_count   = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: vector table plus scoreboard-driven sequences.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        am;
    logic [7:0]  strb;   // S, load, RF, Size, RW, En, BL, B
    logic        valid;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [31:0] pd;
    logic [11:0] sh;
    logic [3:0]  rd;
    logic [31:0] npc;
  } word_t;

  typedef struct packed {
    word_t      w;
    logic [3:0] bub;
    logic [3:0] fl;
  } exp_t;

  typedef struct {
    logic        st, nop, fl;
    logic [3:0]  op;
    logic        v;
    logic [31:0] pb;
    logic [3:0]  exp_op;
    logic        exp_v;
    logic [31:0] exp_pb;
  } vec_t;

  logic clk = 0;
  logic rst_n = 0;
  logic stall = 0, nop_sel = 0, flush = 0;
  word_t id_w = '0;
  word_t ex_w;
  logic [3:0] bubble_count, flush_count;

  logic [3:0] ex_opcode, ex_rd;
  logic ex_am, ex_s, ex_ld, ex_rf, ex_sz, ex_rw, ex_en, ex_bl, ex_b, ex_v;
  logic [31:0] ex_pa, ex_pb, ex_pd, ex_npc;
  logic [11:0] ex_sh;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.STATS_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_opcode(id_w.opcode), .ID_AM(id_w.am),
    .ID_S_enable(id_w.strb[7]), .ID_load_instr(id_w.strb[6]),
    .ID_RF_enable(id_w.strb[5]), .ID_Size_enable(id_w.strb[4]),
    .ID_RW_enable(id_w.strb[3]), .ID_Enable_signal(id_w.strb[2]),
    .ID_BL_instr(id_w.strb[1]), .ID_B_instr(id_w.strb[0]),
    .ID_valid(id_w.valid), .ID_PA(id_w.pa), .ID_PB(id_w.pb), .ID_PD(id_w.pd),
    .ID_shift_imm(id_w.sh), .ID_Rd(id_w.rd), .ID_next_pc(id_w.npc),
    .stall(stall), .nop_sel(nop_sel), .flush(flush),
    .EX_opcode(ex_opcode), .EX_AM(ex_am),
    .EX_S_enable(ex_s), .EX_load_instr(ex_ld), .EX_RF_enable(ex_rf),
    .EX_Size_enable(ex_sz), .EX_RW_enable(ex_rw), .EX_Enable_signal(ex_en),
    .EX_BL_instr(ex_bl), .EX_B_instr(ex_b), .EX_valid(ex_v),
    .EX_PA(ex_pa), .EX_PB(ex_pb), .EX_PD(ex_pd), .EX_shift_imm(ex_sh),
    .EX_Rd(ex_rd), .EX_next_pc(ex_npc),
    .bubble_count(bubble_count), .flush_count(flush_count)
  );

  assign ex_w = '{opcode: ex_opcode, am: ex_am,
                  strb: {ex_s, ex_ld, ex_rf, ex_sz, ex_rw, ex_en, ex_bl, ex_b},
                  valid: ex_v, pa: ex_pa, pb: ex_pb, pd: ex_pd, sh: ex_sh,
                  rd: ex_rd, npc: ex_npc};

  int n_tests = 0;
  int n_fail = 0;
  word_t model_w = '0;
  int bub_m = 0;
  int fl_m = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] cnt_exp(input int m);
`ifdef ID_EX_STATS_EN
    return m[3:0];
`else
    return 4'd0;
`endif
  endfunction

  task automatic model_reset();
    model_w = '0;
    bub_m = 0;
    fl_m = 0;
    sb.delete();
  endtask

  // Apply one edge: predict, push, clock, pop, compare.
  task automatic step(input logic st, input logic nop, input logic fl, input string name);
    exp_t e;
    stall = st; nop_sel = nop; flush = fl;
    if (fl) begin
      model_w.opcode = '0; model_w.am = 0; model_w.strb = '0; model_w.valid = 0;
      if (fl_m < 15) fl_m++;
    end else if (st) begin
      // hold
    end else if (nop) begin
      model_w = id_w;
      model_w.opcode = '0; model_w.am = 0; model_w.strb = '0; model_w.valid = 0;
      if (bub_m < 15) bub_m++;
    end else begin
      model_w = id_w;
      if (!id_w.valid) begin
        model_w.opcode = '0; model_w.am = 0; model_w.strb = '0;
      end
    end
    e.w = model_w; e.bub = cnt_exp(bub_m); e.fl = cnt_exp(fl_m);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({name, ".word"}, {2'b0, ex_w}, {2'b0, e.w});
    chk({name, ".bub"}, {156'b0, bubble_count}, {156'b0, e.bub});
    chk({name, ".fl"}, {156'b0, flush_count}, {156'b0, e.fl});
  endtask

  task automatic rand_id();
    id_w.opcode = 4'($urandom); id_w.am = 1'($urandom); id_w.strb = 8'($urandom);
    id_w.valid = 1; id_w.pa = $urandom; id_w.pb = $urandom; id_w.pd = $urandom;
    id_w.sh = 12'($urandom); id_w.rd = 4'($urandom); id_w.npc = $urandom;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0,0,0, 4'h4,1, 32'h1, 4'h4,1, 32'h1};
    vecs[1] = '{1,0,0, 4'hF,1, 32'h2, 4'h4,1, 32'h1};
    vecs[2] = '{0,1,0, 4'h7,1, 32'hDEAD_BEEF, 4'h0,0, 32'hDEAD_BEEF};
    vecs[3] = '{0,0,0, 4'h9,0, 32'h3, 4'h0,0, 32'h3};
    vecs[4] = '{0,0,0, 4'h9,1, 32'h4, 4'h9,1, 32'h4};
    vecs[5] = '{1,0,1, 4'h2,1, 32'h5, 4'h0,0, 32'h4};
    vecs[6] = '{1,1,0, 4'h3,1, 32'h6, 4'h0,0, 32'h4};
    vecs[7] = '{0,0,0, 4'hA,1, 32'h7, 4'hA,1, 32'h7};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.word", {2'b0, ex_w}, 160'd0);
    chk("reset.cnt", {152'b0, bubble_count, flush_count}, 160'd0);
    @(negedge clk); rst_n = 1;
    model_reset();

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      rand_id();
      id_w.opcode = vecs[i].op; id_w.valid = vecs[i].v; id_w.pb = vecs[i].pb;
      step(vecs[i].st, vecs[i].nop, vecs[i].fl, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.op", i), {156'b0, ex_opcode}, {156'b0, vecs[i].exp_op});
      chk($sformatf("vec%0d.v", i), {159'b0, ex_v}, {159'b0, vecs[i].exp_v});
      chk($sformatf("vec%0d.pb", i), {128'b0, ex_pb}, {128'b0, vecs[i].exp_pb});
    end

    // Normal flow
    id_w = '0; id_w.opcode = 4'b0100; id_w.strb[5] = 1; id_w.rd = 4'd3;
    id_w.pa = 32'h0000_0005; id_w.valid = 1;
    step(0, 0, 0, "normal");
    chk("normal.fields", {144'b0, ex_opcode, ex_rf, ex_v, ex_rd, ex_pa[5:0]},
        {144'b0, 4'b0100, 1'b1, 1'b1, 4'd3, 6'd5});

    // Stall hold for 3 edges, then resume
    id_w.opcode = 4'b0010;
    step(0, 0, 0, "stall.load");
    id_w.opcode = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, $sformatf("stall%0d", i));
      chk($sformatf("stall%0d.op", i), {156'b0, ex_opcode}, {156'b0, 4'b0010});
    end
    step(0, 0, 0, "stall.resume");
    chk("stall.resume.op", {156'b0, ex_opcode}, {156'b0, 4'b1111});

    // Bubble
    id_w.strb[3] = 1; id_w.pb = 32'hDEAD_BEEF;
    step(0, 1, 0, "bubble");
    chk("bubble.fields", {126'b0, ex_rw, ex_v, ex_pb}, {126'b0, 1'b0, 1'b0, 32'hDEAD_BEEF});

    // Flush with stall: control cleared, data held
    rand_id(); id_w.strb[0] = 1;
    step(0, 0, 0, "preflush");
    rand_id(); id_w.strb[0] = 1;
    step(1, 0, 1, "flush.stall");
    chk("flush.ctrl", {146'b0, ex_opcode, ex_am, ex_s, ex_ld, ex_rf, ex_sz, ex_rw, ex_en,
                       ex_bl, ex_b, ex_v}, 160'd0);

    // Saturation of bubble counter
    for (int i = 0; i < 20; i++) begin
      rand_id();
      step(0, 1, 0, $sformatf("sat%0d", i));
    end
`ifdef ID_EX_STATS_EN
    chk("sat.const", {156'b0, bubble_count}, {156'b0, 4'hF});
`else
    chk("sat.const", {156'b0, bubble_count}, 160'd0);
`endif
    step(0, 1, 0, "sat.hold");

    // Asynchronous reset mid-stall, between clock edges
    rand_id();
    step(0, 0, 1, "prerst.flush");
    step(0, 0, 0, "prerst.load");
    stall = 1;
    #2 rst_n = 0;
    #1;
    chk("arst.word", {2'b0, ex_w}, 160'd0);
    chk("arst.cnt", {152'b0, bubble_count, flush_count}, 160'd0);
    @(posedge clk); #1;
    chk("arst.hold", {2'b0, ex_w}, 160'd0);
    @(negedge clk); rst_n = 1;
    model_reset();
    stall = 0;
    rand_id();
    step(0, 0, 0, "postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
